// File: rtl/ram_tester_pkg.sv
// Shared constants, FSM states, read-pipe entry and data pattern for the RAM burst tester.
package ram_tester_pkg;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_entry_t;

    // Data written to (and expected back from) a given address.
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] addr, input logic [DW-1:0] seed);
        return {{(DW-AW){1'b0}}, addr} ^ seed;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-tracking shift register: carries {valid, addr, expected} alongside the RAM read latency.
module ram_rd_pipe
    import ram_tester_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_exp,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_exp
);

    rd_entry_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= '{valid: in_valid, addr: in_addr, exp: in_exp};
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid = stage_q[DEPTH-1].valid;
    assign out_addr  = stage_q[DEPTH-1].addr;
    assign out_exp   = stage_q[DEPTH-1].exp;

endmodule

// File: rtl/ram_burst_tester.sv
// Self-test master for the 4096x16 single-port RAM: strided write burst, read-back, compare.
module ram_burst_tester #(
    parameter int unsigned AW     = ram_tester_pkg::AW,
    parameter int unsigned DW     = ram_tester_pkg::DW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    input  logic [AW:0]   count,
    input  logic [DW-1:0] seed,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_en,
    output logic          ram_read,
    output logic          ram_write,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic          err
);

    import ram_tester_pkg::*;

    localparam int unsigned CW = AW + 1;

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, stride_q;
    logic [CW-1:0] count_q, cnt_q, cnt_d;
    logic [DW-1:0] seed_q;

    logic [AW-1:0] step_addr, addr_d;
    logic [DW-1:0] wdata_d;
    logic          en_d, read_d, write_d, busy_d, done_d;
    logic          load, push;

    logic          pv;
    logic [AW-1:0] pa;
    logic [DW-1:0] pe;
    logic          miss;

    assign step_addr = ram_addr + stride_q;

    // Next state and next registered RAM/status outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;
        en_d    = 1'b0;
        read_d  = 1'b0;
        write_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        load    = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    load   = 1'b1;
                    busy_d = 1'b1;
                    if (count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WRITE;
                        addr_d  = base;
                        wdata_d = pattern(base, seed);
                        en_d    = 1'b1;
                        read_d  = 1'b1;
                        write_d = 1'b1;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WRITE: begin
                if (cnt_q != count_q) begin
                    addr_d  = step_addr;
                    wdata_d = pattern(step_addr, seed_q);
                    en_d    = 1'b1;
                    read_d  = 1'b1;
                    write_d = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    state_d = READ;
                    addr_d  = base_q;
                    en_d    = 1'b1;
                    read_d  = 1'b1;
                    push    = 1'b1;
                    cnt_d   = CW'(1);
                end
            end
            READ: begin
                if (cnt_q != count_q) begin
                    addr_d = step_addr;
                    en_d   = 1'b1;
                    read_d = 1'b1;
                    push   = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end else begin
                    state_d = DRAIN;
                    cnt_d   = CW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(RD_LAT)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            count_q   <= '0;
            seed_q    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_en    <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            ram_en    <= en_d;
            ram_read  <= read_d;
            ram_write <= write_d;
            busy      <= busy_d;
            done      <= done_d;
            if (load) begin
                base_q   <= base;
                stride_q <= stride;
                count_q  <= count;
                seed_q   <= seed;
            end
        end
    end

    // Entry is pushed as the read address is registered, so it lines up with returning data.
    ram_rd_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_addr   (addr_d),
        .in_exp    (pattern(addr_d, seed_q)),
        .out_valid (pv),
        .out_addr  (pa),
        .out_exp   (pe)
    );

    assign miss = pv && (ram_rdata != pe);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            err            <= 1'b0;
        end else if (miss) begin
            err_cnt <= err_cnt + CW'(1);
            err     <= 1'b1;
            if (err_cnt == '0) begin
                first_err_addr <= pa;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_tester.sv
// Directed bench: two testers (read latency 1 and 3) driven in lock-step, each with its own RAM model.
module tb_ram_burst_tester;

    import ram_tester_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [11:0] base, stride;
    logic [12:0] count;
    logic [15:0] seed;
    logic        stuck;

    logic [11:0] a1, fa1, a3, fa3;
    logic [15:0] wd1, rd1, wd3, rd3;
    logic        en1, r1, w1, busy1, done1, err1;
    logic        en3, r3, w3, busy3, done3, err3;
    logic [12:0] ec1, ec3;

    logic [15:0] mem1 [4096];
    logic [15:0] mem3 [4096];
    logic [15:0] rd3_d1, rd3_d2;
    logic [15:0] rd3_0;

    int cyc = 0, n_cmp = 0, n_err = 0;
    int en1_n = 0, en3_n = 0, done1_n = 0, done3_n = 0, done1_cyc = 0, done3_cyc = 0;
    int c0, c1, t3, snap_en1, snap_en3, snap_d1, snap_d3;
    logic [3:0]  s_ctl;
    logic [11:0] s_addr;
    logic [15:0] s_data;

    always #5 clk = ~clk;

    ram_burst_tester #(.AW(12), .DW(16), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .base(base), .stride(stride), .count(count), .seed(seed),
        .ram_addr(a1), .ram_wdata(wd1), .ram_rdata(rd1), .ram_en(en1), .ram_read(r1), .ram_write(w1),
        .busy(busy1), .done(done1), .err_cnt(ec1), .first_err_addr(fa1), .err(err1)
    );

    ram_burst_tester #(.AW(12), .DW(16), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .base(base), .stride(stride), .count(count), .seed(seed),
        .ram_addr(a3), .ram_wdata(wd3), .ram_rdata(rd3), .ram_en(en3), .ram_read(r3), .ram_write(w3),
        .busy(busy3), .done(done3), .err_cnt(ec3), .first_err_addr(fa3), .err(err3)
    );

    // RAM models; addresses 514 and 2050 optionally read back as zero.
    always @(posedge clk) begin
        if (en1 && w1) mem1[a1] <= wd1;
        if (en3 && w3) mem3[a3] <= wd3;
        rd3_d1 <= rd3_0;
        rd3_d2 <= rd3_d1;
    end
    assign rd1   = (stuck && (a1 == 12'd514 || a1 == 12'd2050)) ? 16'h0000 : mem1[a1];
    assign rd3_0 = (stuck && (a3 == 12'd514 || a3 == 12'd2050)) ? 16'h0000 : mem3[a3];
    assign rd3   = rd3_d2;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en1) en1_n <= en1_n + 1;
        if (en3) en3_n <= en3_n + 1;
        if (done1) begin
            done1_n   <= done1_n + 1;
            done1_cyc <= cyc;
        end
        if (done3) begin
            done3_n   <= done3_n + 1;
            done3_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One run; c0 is the cycle in which start is sampled, t3 the offset of done on the RD_LAT=3 tester.
    task automatic run(input logic [11:0] b, input logic [11:0] s, input logic [12:0] n, input logic [15:0] sd);
        int i, d1s, d3s;
        step();
        base = b; stride = s; count = n; seed = sd; start = 1'b1;
        c0 = cyc; d1s = done1_n; d3s = done3_n;
        step();
        start = 1'b0; base = '0; stride = '0; count = '0; seed = 16'hFFFF;
        s_ctl = {en1, r1, w1, busy1}; s_addr = a1; s_data = wd1;
        i = 0;
        while (!done3 && i < 2 * int'(n) + 20) begin
            step();
            i++;
        end
        t3 = cyc - c0;
        step();
        chk("done1_pulses", 32'(done1_n - d1s), 32'd1);
        chk("done3_pulses", 32'(done3_n - d3s), 32'd1);
    endtask

    initial begin
        int bad1, bad3;
        rst = 1'b1; start = 1'b0; base = '0; stride = '0; count = '0; seed = '0; stuck = 1'b0;
        repeat (3) step();
        chk("reset_outputs1", 32'({a1, wd1, en1, r1, w1, busy1, done1, ec1, fa1, err1} != 0), 32'd0);
        chk("reset_outputs3", 32'({a3, wd3, en3, r3, w3, busy3, done3, ec3, fa3, err3} != 0), 32'd0);
        rst = 1'b0;
        step();

        // base=2 stride=512 count=8 seed=0
        run(12'd2, 12'd512, 13'd8, 16'h0000);
        chk("t1_first_ctl", 32'(s_ctl), 32'hF);
        chk("t1_first_addr", 32'(s_addr), 32'd2);
        chk("t1_first_data", 32'(s_data), 32'd2);
        chk("t1_done1_cyc", 32'(done1_cyc - c0), 32'd18);
        chk("t1_done3_cyc", 32'(t3), 32'd20);
        chk("t1_errcnt1", 32'(ec1), 32'd0);
        chk("t1_errcnt3", 32'(ec3), 32'd0);
        chk("t1_mem1_514", 32'(mem1[514]), 32'd514);
        chk("t1_mem3_3586", 32'(mem3[3586]), 32'd3586);
        chk("t1_busy_low", 32'({busy1, busy3}), 32'd0);

        // wrapping addresses with a seed
        run(12'd4000, 12'd100, 13'd5, 16'hA5A5);
        chk("t2_done1_cyc", 32'(done1_cyc - c0), 32'd12);
        chk("t2_errcnt1", 32'(ec1), 32'd0);
        chk("t2_errcnt3", 32'(ec3), 32'd0);
        chk("t2_mem1_4", 32'(mem1[4]), 32'hA5A1);
        chk("t2_mem3_4000", 32'(mem3[4000]), 32'hAA05);
        chk("t2_mem1_304", 32'(mem1[304]), 32'hA495);

        // stuck-at-zero locations 514 and 2050
        stuck = 1'b1;
        run(12'd2, 12'd512, 13'd8, 16'h0000);
        chk("t3_errcnt1", 32'(ec1), 32'd2);
        chk("t3_first1", 32'(fa1), 32'd514);
        chk("t3_err1", 32'(err1), 32'd1);
        chk("t3_errcnt3", 32'(ec3), 32'd2);
        chk("t3_first3", 32'(fa3), 32'd514);
        chk("t3_err3", 32'(err3), 32'd1);
        step();
        chk("t3_hold", 32'({ec1, fa1}), {19'd0, 13'd2} << 12 | 32'd514);

        // count = 0
        snap_en1 = en1_n; snap_en3 = en3_n;
        run(12'd7, 12'd1, 13'd0, 16'h0000);
        chk("c0_done1_cyc", 32'(done1_cyc - c0), 32'd1);
        chk("c0_done3_cyc", 32'(t3), 32'd1);
        chk("c0_first_ctl", 32'(s_ctl), 32'h1);
        chk("c0_no_ram", 32'((en1_n - snap_en1) + (en3_n - snap_en3)), 32'd0);
        chk("c0_err_cleared", 32'({ec1, fa1, err1}), 32'd0);

        // reset during the 3rd read cycle
        step();
        base = 12'd2; stride = 12'd512; count = 13'd8; seed = '0; start = 1'b1; c0 = cyc;
        snap_d1 = done1_n; snap_d3 = done3_n;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("rst_pre_errcnt1", 32'(ec1), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ctl1", 32'({en1, r1, w1, busy1, done1}), 32'd0);
        chk("rst_ctl3", 32'({en3, r3, w3, busy3, done3}), 32'd0);
        chk("rst_errcnt", 32'({ec1, ec3}), 32'd0);
        snap_en1 = en1_n; snap_en3 = en3_n;
        repeat (12) step();
        chk("rst_no_done", 32'((done1_n - snap_d1) + (done3_n - snap_d3)), 32'd0);
        chk("rst_no_ram", 32'((en1_n - snap_en1) + (en3_n - snap_en3)), 32'd0);
        chk("rst_errcnt_idle", 32'({ec1, ec3}), 32'd0);
        stuck = 1'b0;
        run(12'd2, 12'd512, 13'd8, 16'h0000);
        chk("rst_rerun_cyc", 32'(t3), 32'd20);
        chk("rst_rerun_err", 32'({ec1, ec3}), 32'd0);

        // start while busy is ignored; start right after done is accepted
        step();
        base = 12'd10; stride = 12'd3; count = 13'd4; seed = 16'h0F0F; start = 1'b1; c0 = cyc;
        snap_d3 = done3_n;
        step();
        start = 1'b0;
        step();
        step();
        base = 12'd0; count = 13'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && !done3; i++) step();
        chk("rs_done3_cyc", 32'(cyc - c0), 32'd12);
        step();
        base = 12'd100; stride = 12'd7; count = 13'd3; seed = 16'h1111; start = 1'b1; c1 = cyc;
        step();
        start = 1'b0;
        chk("rs_accepted", 32'({busy1, busy3, en3, w3}), 32'hF);
        chk("rs_addr", 32'(a3), 32'd100);
        for (int i = 0; i < 40 && !done3; i++) step();
        chk("rs2_done3_cyc", 32'(cyc - c1), 32'd10);
        step();
        chk("rs2_done1_cyc", 32'(done1_cyc - c1), 32'd8);
        chk("rs_done3_pulses", 32'(done3_n - snap_d3), 32'd2);
        chk("rs_mem3_114", 32'(mem3[114]), 32'h1163);

        // full 4096-location sweep
        run(12'd0, 12'd1, 13'd4096, 16'h1234);
        chk("full_done1_cyc", 32'(done1_cyc - c0), 32'd8194);
        chk("full_done3_cyc", 32'(t3), 32'd8196);
        chk("full_err", 32'({ec1, ec3}), 32'd0);
        bad1 = 0; bad3 = 0;
        for (int i = 0; i < 4096; i++) begin
            if (mem1[i] !== pattern(12'(i), 16'h1234)) bad1++;
            if (mem3[i] !== pattern(12'(i), 16'h1234)) bad3++;
        end
        chk("full_mem1", 32'(bad1), 32'd0);
        chk("full_mem3", 32'(bad3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
